// File: rtl/trade_report_tx.sv
// Serialises one trade result as a framed UART 8N1 packet:
// HEADER, {6'b0,action}, profit[15:8], profit[7:0], checksum, FOOTER.
module trade_report_tx #(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 9600,
    parameter logic [7:0] HEADER   = 8'hAA,
    parameter logic [7:0] FOOTER   = 8'h55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        report_valid,
    output logic        report_ready,
    input  logic [1:0]  action,
    input  logic [15:0] profit,
    output logic        uart_tx,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  dbg_state
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [2:0]       byte_idx, byte_idx_n;
    logic [1:0]       action_q;
    logic [15:0]      profit_q;
    logic [7:0]       byte_n;
    logic             tx_n, done_n, accept, bit_end;

    // Handshake: a result transfers on the rising edge where report_valid && report_ready;
    // ready is high only in IDLE, so valid held during a frame is simply not seen until IDLE.
    assign accept       = report_valid && report_ready;
    assign report_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign dbg_state    = state;
    assign bit_end      = (baud_cnt == BAUD_LAST);

    function automatic logic [7:0] frame_byte(input logic [2:0] idx);
        logic [7:0] b1;
        b1 = {6'b0, action_q};
        case (idx)
            3'd0:    frame_byte = HEADER;
            3'd1:    frame_byte = b1;
            3'd2:    frame_byte = profit_q[15:8];
            3'd3:    frame_byte = profit_q[7:0];
            3'd4:    frame_byte = b1 ^ profit_q[15:8] ^ profit_q[7:0];
            default: frame_byte = FOOTER;
        endcase
    endfunction

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (report_valid) begin
                    state_n    = START;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                end
            end
            START: begin
                baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
                if (bit_end) begin
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
                if (bit_end) begin
                    if (byte_idx < 3'd5) begin
                        byte_idx_n = byte_idx + 1'b1;
                        state_n    = START;
                    end else begin
                        byte_idx_n = '0;
                        state_n    = IDLE;
                        done_n     = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is derived from the next state so the registered output moves only on bit boundaries.
        byte_n = frame_byte(byte_idx_n);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = byte_n[bit_idx_n];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            action_q   <= '0;
            profit_q   <= '0;
            uart_tx    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            uart_tx    <= tx_n;
            frame_done <= done_n;
            if (accept) begin
                action_q <= action;
                profit_q <= profit;
            end
        end
    end

endmodule
